// File: rtl/psram_arbiter_pkg.sv
// Shared types and constants for the PSRAM two-port arbiter (package psram_pkg).
package psram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_RESPOND
  } ArbState;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_VIC = 1'b1;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;
  localparam logic [7:0] RDATA_ERR = 8'hFF;

  // tie_port decides only when both ports request; a lone request always wins.
  function automatic logic arb_pick(input logic req0, input logic req1, input logic tie_port);
    if (req0 && req1) return tie_port;
    return req1 ? PORT_VIC : PORT_CPU;
  endfunction

endpackage

// File: rtl/psram_arbiter_timeout.sv
// Saturating transaction timer for the PSRAM arbiter; expired_o flags the cycle
// in which the count reaches MAX_COUNT.
module arb_timeout_counter #(
  parameter int MAX_COUNT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int TW = $clog2(MAX_COUNT + 1);
  localparam logic [TW-1:0] MAX_V = TW'(MAX_COUNT);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != MAX_V)) begin
      count_d = count_q + TW'(1);
    end
  end

  // Looking at count_d lets the controller react on the edge the limit is reached.
  assign expired_o = enable_i && (count_d == MAX_V);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/psram_arbiter.sv
// Two-port (CPU / VIC-II) arbiter and sequencer in front of the PSRAM controller.
// Optional PSRAM_ARB_ROUND_ROBIN_EN: alternate ties; otherwise VIC-II wins ties.
module psram_arbiter
  import psram_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [15:0] addr0,
  input  logic [7:0]  wdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  rdata0,
  output logic [7:0]  rdata1,
  output logic        err,
  output logic        mem_ce,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_busy,
  input  logic [7:0]  mem_rdata
);

  ArbState     state_q;
  logic        grant_q;
  logic        ack0_q, ack1_q, err_q, mem_ce_q, mem_write_q;
  logic [15:0] mem_addr_q;
  logic [7:0]  mem_wdata_q, rdata0_q, rdata1_q;

  logic tie_port, winner;
  logic tmr_clear, tmr_en, tmr_expired;
  logic done_ok, done_err;
  logic [7:0] resp_data;

`ifdef PSRAM_ARB_ROUND_ROBIN_EN
  logic last_q;
  assign tie_port = ~last_q;
`else
  assign tie_port = PORT_VIC;
`endif

  assign winner = arb_pick(req0, req1, tie_port);

  assign tmr_clear = (state_q == ST_ISSUE) || ((state_q == ST_WAIT_BUSY) && mem_busy);
  assign tmr_en    = ((state_q == ST_WAIT_BUSY) && !mem_busy) ||
                     ((state_q == ST_WAIT_DONE) && mem_busy);

  arb_timeout_counter #(
    .MAX_COUNT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (tmr_clear),
    .enable_i  (tmr_en),
    .expired_o (tmr_expired)
  );

  assign done_ok   = (state_q == ST_WAIT_DONE) && !mem_busy;
  assign done_err  = tmr_en && tmr_expired;
  assign resp_data = done_err ? RDATA_ERR : mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= PORT_CPU;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_ce_q    <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      rdata0_q    <= 8'h00;
      rdata1_q    <= 8'h00;
`ifdef PSRAM_ARB_ROUND_ROBIN_EN
      last_q      <= PORT_VIC;
`endif
    end else begin
      mem_ce_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!mem_busy && (req0 || req1)) begin
            grant_q     <= winner;
            mem_write_q <= winner ? we1 : we0;
            mem_addr_q  <= winner ? addr1 : addr0;
            mem_wdata_q <= winner ? wdata1 : wdata0;
            mem_ce_q    <= 1'b1;
            state_q     <= ST_ISSUE;
`ifdef PSRAM_ARB_ROUND_ROBIN_EN
            last_q      <= winner;
`endif
          end
        end
        ST_ISSUE:     state_q <= ST_WAIT_BUSY;
        ST_WAIT_BUSY: if (mem_busy) state_q <= ST_WAIT_DONE;
        ST_WAIT_DONE: ;
        ST_RESPOND:   state_q <= ST_IDLE;
        default:      state_q <= ST_IDLE;
      endcase
      // Completion, normal or timed out, from either wait state.
      if (done_ok || done_err) begin
        state_q <= ST_RESPOND;
        err_q   <= done_err;
        if (grant_q == PORT_VIC) ack1_q <= 1'b1;
        else                     ack0_q <= 1'b1;
        if (!mem_write_q) begin
          if (grant_q == PORT_VIC) rdata1_q <= resp_data;
          else                     rdata0_q <= resp_data;
        end
      end
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err       = err_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_ce    = mem_ce_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter with a small behavioural PSRAM controller model.
module tb_psram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic [7:0]  wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, err, mem_ce, mem_write;
  logic [7:0]  rdata0, rdata1, mem_wdata;
  logic [15:0] mem_addr;
  logic        mem_busy;
  logic [7:0]  mem_rdata = 8'h00;

  logic ctl_busy = 1'b0, force_busy = 1'b0, ctl_auto = 1'b1;
  int   ctl_cnt = 0, ctl_len = 1;
  int   n_checks = 0, n_fail = 0;

  assign mem_busy = ctl_busy | force_busy;

  always #5 clk = ~clk;

  psram_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .err(err),
    .mem_ce(mem_ce), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_busy(mem_busy), .mem_rdata(mem_rdata)
  );

  // Controller model: busy rises the cycle after mem_ce and stays up ctl_len cycles.
  always @(posedge clk) begin
    if (reset) begin
      ctl_busy <= 1'b0;
      ctl_cnt  <= 0;
    end else if (mem_ce && ctl_auto) begin
      ctl_busy <= 1'b1;
      ctl_cnt  <= ctl_len;
    end else if (ctl_cnt == 1) begin
      ctl_busy <= 1'b0;
      ctl_cnt  <= 0;
    end else if (ctl_cnt > 1) begin
      ctl_cnt <= ctl_cnt - 1;
    end
  end

  // k = 0 is the first edge after the request was raised; lat is the k at which ack is seen.
  task automatic wait_ack(input int bound, input bit drop, output int lat, output logic a0,
                          output logic a1, output logic e, output int ce_cnt,
                          output logic [15:0] ce_addr, output logic ce_we, output logic [7:0] ce_wd);
    lat = -1; a0 = 0; a1 = 0; e = 0; ce_cnt = 0; ce_addr = '0; ce_we = 0; ce_wd = '0;
    for (int k = 0; k < bound; k++) begin
      @(posedge clk); #1;
      if (mem_ce) begin ce_cnt++; ce_addr = mem_addr; ce_we = mem_write; ce_wd = mem_wdata; end
      if (ack0 || ack1) begin
        lat = k; a0 = ack0; a1 = ack1; e = err;
        if (drop && ack0) req0 = 1'b0;
        if (drop && ack1) req1 = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if ({ack0, ack1, err, mem_ce, mem_write} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {ack0, ack1, err, mem_ce, mem_write}); end
    n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h want 0000", mem_addr); end
    n_checks++; if ({mem_wdata, rdata0, rdata1} !== 24'h0) begin n_fail++; $display("FAIL reset_data: got %h want 000000", {mem_wdata, rdata0, rdata1}); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (mem_ce !== 1'b0) begin n_fail++; $display("FAIL idle_no_ce: got %b want 0", mem_ce); end
  endtask

  task automatic test_read0();
    int lat, cc; logic a0, a1, e, cw; logic [15:0] ca; logic [7:0] cd;
    ctl_len = 1; mem_rdata = 8'hA5;
    req0 = 1; we0 = 0; addr0 = 16'h1234;
    wait_ack(20, 1, lat, a0, a1, e, cc, ca, cw, cd);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL read0_latency: got %0d want 3", lat); end
    n_checks++; if (cc !== 1 || ca !== 16'h1234 || cw !== 1'b0) begin n_fail++; $display("FAIL read0_issue: ce=%0d addr=%h we=%b want 1 1234 0", cc, ca, cw); end
    n_checks++; if ({a0, a1, e} !== 3'b100) begin n_fail++; $display("FAIL read0_ack: got %b want 100", {a0, a1, e}); end
    n_checks++; if (rdata0 !== 8'hA5) begin n_fail++; $display("FAIL read0_data: got %h want a5", rdata0); end
    @(posedge clk); #1;
    n_checks++; if (ack0 !== 1'b0) begin n_fail++; $display("FAIL read0_ack_pulse: got %b want 0", ack0); end
    mem_rdata = 8'h3C;
    req1 = 1; we1 = 0; addr1 = 16'hD012;
    wait_ack(20, 1, lat, a0, a1, e, cc, ca, cw, cd);
    n_checks++; if ({a0, a1, e} !== 3'b010 || rdata1 !== 8'h3C) begin n_fail++; $display("FAIL read1: ack=%b rdata1=%h want 010 3c", {a0, a1, e}, rdata1); end
    n_checks++; if (rdata0 !== 8'hA5) begin n_fail++; $display("FAIL read1_other_port: got %h want a5", rdata0); end
    @(posedge clk); #1;
  endtask

  task automatic test_write1();
    int lat, cc; logic a0, a1, e, cw; logic [15:0] ca; logic [7:0] cd;
    mem_rdata = 8'h5A;
    req1 = 1; we1 = 1; addr1 = 16'hD020; wdata1 = 8'h0E;
    wait_ack(20, 1, lat, a0, a1, e, cc, ca, cw, cd);
    n_checks++; if (cw !== 1'b1 || cd !== 8'h0E || ca !== 16'hD020) begin n_fail++; $display("FAIL write1_issue: we=%b wd=%h addr=%h want 1 0e d020", cw, cd, ca); end
    n_checks++; if (lat !== 3 || {a0, a1, e} !== 3'b010) begin n_fail++; $display("FAIL write1_ack: lat=%0d ack=%b want 3 010", lat, {a0, a1, e}); end
    n_checks++; if (rdata1 !== 8'h3C) begin n_fail++; $display("FAIL write1_rdata_kept: got %h want 3c", rdata1); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat, cc; logic a0, a1, e, cw; logic [15:0] ca; logic [7:0] cd;
    logic exp_w;
    req0 = 1; we0 = 1; addr0 = 16'h0100; wdata0 = 8'h01;
    req1 = 1; we1 = 1; addr1 = 16'h0200; wdata1 = 8'h02;
    for (int r = 0; r < 4; r++) begin
`ifdef PSRAM_ARB_ROUND_ROBIN_EN
      exp_w = (r % 2 == 1);
`else
      exp_w = 1'b1;
`endif
      wait_ack(20, 0, lat, a0, a1, e, cc, ca, cw, cd);
      n_checks++; if (a1 !== exp_w || a0 !== !exp_w) begin n_fail++; $display("FAIL b2b_winner_%0d: ack0=%b ack1=%b want ack1=%b", r, a0, a1, exp_w); end
      n_checks++; if (ca !== (exp_w ? 16'h0200 : 16'h0100) || cd !== (exp_w ? 8'h02 : 8'h01)) begin n_fail++; $display("FAIL b2b_addr_%0d: addr=%h wd=%h winner=%b", r, ca, cd, exp_w); end
      n_checks++; if (lat !== (r == 0 ? 3 : 4)) begin n_fail++; $display("FAIL b2b_latency_%0d: got %0d want %0d", r, lat, (r == 0 ? 3 : 4)); end
    end
    req0 = 0; req1 = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_timeout_busy();
    int lat, cc; logic a0, a1, e, cw; logic [15:0] ca; logic [7:0] cd;
    ctl_auto = 0;
    req0 = 1; we0 = 0; addr0 = 16'h0040;
    wait_ack(40, 1, lat, a0, a1, e, cc, ca, cw, cd);
    n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL timeout_busy_latency: got %0d want 9", lat); end
    n_checks++; if ({a0, a1, e} !== 3'b101) begin n_fail++; $display("FAIL timeout_busy_ack_err: got %b want 101", {a0, a1, e}); end
    n_checks++; if (rdata0 !== 8'hFF) begin n_fail++; $display("FAIL timeout_busy_rdata: got %h want ff", rdata0); end
    @(posedge clk); #1;
    n_checks++; if ({ack0, err} !== 2'b00) begin n_fail++; $display("FAIL timeout_err_pulse: got %b want 00", {ack0, err}); end
    ctl_auto = 1;
  endtask

  task automatic test_timeout_done();
    int lat, cc; logic a0, a1, e, cw; logic [15:0] ca; logic [7:0] cd;
    ctl_len = 20; mem_rdata = 8'h77;
    req1 = 1; we1 = 0; addr1 = 16'h0041;
    wait_ack(40, 1, lat, a0, a1, e, cc, ca, cw, cd);
    n_checks++; if (lat !== 10 || {a0, a1, e} !== 3'b011) begin n_fail++; $display("FAIL timeout_done: lat=%0d ack=%b want 10 011", lat, {a0, a1, e}); end
    n_checks++; if (rdata1 !== 8'hFF) begin n_fail++; $display("FAIL timeout_done_rdata: got %h want ff", rdata1); end
    for (int i = 0; i < 40 && mem_busy; i++) begin @(posedge clk); #1; end
    n_checks++; if (mem_busy !== 1'b0) begin n_fail++; $display("FAIL ctl_release: busy=%b want 0", mem_busy); end
    ctl_len = 1;
  endtask

  task automatic test_busy_idle();
    int lat, cc, ces; logic a0, a1, e, cw; logic [15:0] ca; logic [7:0] cd;
    ces = 0; mem_rdata = 8'h66;
    force_busy = 1; req0 = 1; we0 = 0; addr0 = 16'h0055;
    repeat (5) begin @(posedge clk); #1; if (mem_ce) ces++; end
    n_checks++; if (ces !== 0) begin n_fail++; $display("FAIL busy_idle_hold: ce count %0d want 0", ces); end
    force_busy = 0;
    wait_ack(20, 1, lat, a0, a1, e, cc, ca, cw, cd);
    n_checks++; if (lat !== 3 || cc !== 1 || ca !== 16'h0055) begin n_fail++; $display("FAIL busy_idle_seq: lat=%0d ce=%0d addr=%h want 3 1 0055", lat, cc, ca); end
    n_checks++; if (rdata0 !== 8'h66 || e !== 1'b0) begin n_fail++; $display("FAIL busy_idle_data: rdata0=%h err=%b want 66 0", rdata0, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat, cc, acks; logic a0, a1, e, cw; logic [15:0] ca; logic [7:0] cd;
    acks = 0; ctl_len = 5; mem_rdata = 8'h11;
    req0 = 1; we0 = 0; addr0 = 16'h7777;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (mem_addr !== 16'h7777) begin n_fail++; $display("FAIL reset_mid_pre: addr=%h want 7777", mem_addr); end
    #2; reset = 1; #1;
    n_checks++; if ({ack0, ack1, err, mem_ce, mem_write, mem_addr, mem_wdata, rdata0, rdata1} !== 45'h0) begin n_fail++; $display("FAIL reset_mid_outputs: got %h want 0", {ack0, ack1, err, mem_ce, mem_write, mem_addr, mem_wdata, rdata0, rdata1}); end
    req0 = 0;
    @(posedge clk); #1;
    reset = 0;
    repeat (4) begin @(posedge clk); #1; if (ack0 || ack1) acks++; end
    n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL reset_mid_no_ack: got %0d acks want 0", acks); end
    ctl_len = 1; mem_rdata = 8'h99;
    req0 = 1; addr0 = 16'h0042;
    wait_ack(20, 1, lat, a0, a1, e, cc, ca, cw, cd);
    n_checks++; if (lat !== 3 || {a0, a1, e} !== 3'b100 || rdata0 !== 8'h99) begin n_fail++; $display("FAIL reset_mid_recover: lat=%0d ack=%b rdata0=%h want 3 100 99", lat, {a0, a1, e}, rdata0); end
  endtask

  initial begin
    test_reset();
    test_read0();
    test_write1();
    test_back_to_back();
    test_timeout_busy();
    test_timeout_done();
    test_busy_idle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
